cp0_interrupt_unit: RTL and testbench

Coprocessor-0 interrupt unit for the single-cycle MIPS core: holds the Status, Cause and EPC registers and consumes the `TimerInterrupt` line produced by the memory-mapped timer. It decides each cycle whether the core takes an interrupt, captures the resume PC, and services `mfc0`/`mtc0`/`eret`. It sits between the timer and the PC-select logic. When `TakenInterrupt` is asserted, the datapath redirects the fetch to 0x80000180.

---
 rtl/cp0_interrupt_unit.sv | 163 ++++++++++++++++
 tb/tb_cp0_interrupt_unit.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cp0_interrupt_unit.sv
// rtl/cp0_interrupt_unit.sv - CP0 Status/Cause/EPC registers and interrupt decision
//
// Coprocessor-0 interrupt unit for the single-cycle MIPS core.
// It holds Status, Cause and EPC, and decides each cycle whether the core takes
// the timer interrupt. It also services mfc0, mtc0 and eret.
//
// Optional feature macro: CP0_SOFTWARE_INT_EN. When it is defined, the software
// interrupts IP1:IP0 in Cause and the masks IM1:IM0 in Status are implemented.
//
// Ports:
//   clock          : single clock; all state changes on its rising edge
//   reset          : synchronous, active-high
//   TimerInterrupt : level request from the memory-mapped timer (IP7)
//   MTC0           : current instruction is mtc0
//   ERET           : current instruction is eret
//   regnum         : CP0 register number (12 Status, 13 Cause, 14 EPC)
//   wr_data        : mtc0 source value
//   next_pc        : word address the core would fetch next; saved to EPC
//   rd_data        : mfc0 read value, combinational on regnum
//   EPC            : saved return word address for the eret PC mux
//   handler_pc     : interrupt vector (HANDLER_ADDR)
//   TakenInterrupt : the interrupt is taken this cycle
module cp0_interrupt_unit #(
  parameter logic [31:0] HANDLER_ADDR = 32'h80000180
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        TimerInterrupt,
  input  logic        MTC0,
  input  logic        ERET,
  input  logic [4:0]  regnum,
  input  logic [31:0] wr_data,
  input  logic [29:0] next_pc,
  output logic [31:0] rd_data,
  output logic [29:0] EPC,
  output logic [31:0] handler_pc,
  output logic        TakenInterrupt
);

  localparam logic [4:0] REG_STATUS = 5'd12;
  localparam logic [4:0] REG_CAUSE  = 5'd13;
  localparam logic [4:0] REG_EPC    = 5'd14;

  // Implemented Status bits
  logic        ie_q,  ie_d;
  logic        exl_q, exl_d;
  logic        im7_q, im7_d;
  logic [29:0] epc_q, epc_d;

  // Software interrupt pending bits and their masks (zero when not built in)
  logic [1:0]  im_sw;
  logic [1:0]  ip_sw;

  logic        wr_status;
  logic        wr_cause;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic [2:0]  pending;

  assign wr_status = MTC0 && (regnum == REG_STATUS);
  assign wr_cause  = MTC0 && (regnum == REG_CAUSE);

`ifdef CP0_SOFTWARE_INT_EN
  logic [1:0] im_sw_q, im_sw_d;
  logic [1:0] ip_sw_q, ip_sw_d;

  assign im_sw = im_sw_q;
  assign ip_sw = ip_sw_q;

  always_comb begin
    im_sw_d = im_sw_q;
    ip_sw_d = ip_sw_q;
    if (wr_status) begin
      im_sw_d = wr_data[9:8];
    end
    if (wr_cause) begin
      ip_sw_d = wr_data[9:8];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      im_sw_q <= 2'b00;
      ip_sw_q <= 2'b00;
    end else begin
      im_sw_q <= im_sw_d;
      ip_sw_q <= ip_sw_d;
    end
  end
`else
  assign im_sw = 2'b00;
  assign ip_sw = 2'b00;
  logic unused_wr_cause;
  assign unused_wr_cause = wr_cause;
`endif

  // Only some wr_data bits are stored; the rest are deliberately dropped.
  logic unused_wr_data;
  assign unused_wr_data = &{1'b0, wr_data};

  // Register images as seen by mfc0. ExcCode[6:2] is always 0 (interrupt).
  assign status_val = {16'h0000, im7_q, 5'b00000, im_sw, 6'b000000, exl_q, ie_q};
  assign cause_val  = {16'h0000, TimerInterrupt, 5'b00000, ip_sw, 8'h00};

  // The timer line is live, not latched, so the interrupt latency is zero cycles.
  assign pending = {TimerInterrupt, ip_sw} & {im7_q, im_sw};

  // An eret in flight blocks the take. A still-high request is retaken one
  // cycle later, once EXL has cleared.
  assign TakenInterrupt = (|pending) & ie_q & ~exl_q & ~ERET;

  always_comb begin
    rd_data = 32'h0000_0000;
    case (regnum)
      REG_STATUS: rd_data = status_val;
      REG_CAUSE:  rd_data = cause_val;
      REG_EPC:    rd_data = {epc_q, 2'b00};
      default:    rd_data = 32'h0000_0000;
    endcase
  end

  // Assignments are ordered lowest priority first, so later ones win:
  // eret clear, then the mtc0 write, then the EXL set by a taken interrupt.
  always_comb begin
    ie_d  = ie_q;
    exl_d = exl_q;
    im7_d = im7_q;
    epc_d = epc_q;

    if (ERET) begin
      exl_d = 1'b0;
    end

    if (wr_status) begin
      ie_d  = wr_data[0];
      exl_d = wr_data[1];
      im7_d = wr_data[15];
    end

    if (TakenInterrupt) begin
      exl_d = 1'b1;
      epc_d = next_pc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      ie_q  <= 1'b0;
      exl_q <= 1'b0;
      im7_q <= 1'b0;
      epc_q <= 30'h0;
    end else begin
      ie_q  <= ie_d;
      exl_q <= exl_d;
      im7_q <= im7_d;
      epc_q <= epc_d;
    end
  end

  assign EPC        = epc_q;
  assign handler_pc = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_interrupt_unit.sv
// tb/tb_cp0_interrupt_unit.sv - table-driven self-checking bench for cp0_interrupt_unit
module tb_cp0_interrupt_unit;

  logic        clock;
  logic        reset;
  logic        TimerInterrupt;
  logic        MTC0;
  logic        ERET;
  logic [4:0]  regnum;
  logic [31:0] wr_data;
  logic [29:0] next_pc;
  logic [31:0] rd_data;
  logic [29:0] EPC;
  logic [31:0] handler_pc;
  logic        TakenInterrupt;

  int checks = 0;
  int errors = 0;

  cp0_interrupt_unit dut (
    .clock          (clock),
    .reset          (reset),
    .TimerInterrupt (TimerInterrupt),
    .MTC0           (MTC0),
    .ERET           (ERET),
    .regnum         (regnum),
    .wr_data        (wr_data),
    .next_pc        (next_pc),
    .rd_data        (rd_data),
    .EPC            (EPC),
    .handler_pc     (handler_pc),
    .TakenInterrupt (TakenInterrupt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        ti;
    logic        mtc0;
    logic        eret;
    logic [4:0]  rn;
    logic [31:0] wd;
    logic [29:0] npc;
    logic [31:0] exp_rd;
    logic [29:0] exp_epc;
    logic        exp_taken;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic ti, input logic mtc0, input logic eret,
                      input logic [4:0] rn, input logic [31:0] wd, input logic [29:0] npc,
                      input logic [31:0] exp_rd, input logic [29:0] exp_epc,
                      input logic exp_taken);
    vec_t v;
    v.ti = ti; v.mtc0 = mtc0; v.eret = eret; v.rn = rn; v.wd = wd; v.npc = npc;
    v.exp_rd = exp_rd; v.exp_epc = exp_epc; v.exp_taken = exp_taken;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ti, input logic mtc0, input logic eret,
                       input logic [4:0] rn, input logic [31:0] wd, input logic [29:0] npc);
    TimerInterrupt = ti; MTC0 = mtc0; ERET = eret; regnum = rn; wr_data = wd; next_pc = npc;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  logic exp_sw_taken;
  logic [31:0] exp_sw_cause;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 30'h0);

    //   ti   mtc0 eret  rn     wd            npc      exp_rd        exp_epc  taken
    addv(1'b0, 1'b0, 1'b0, 5'd12, 32'h0,        30'h0,   32'h0,        30'h0,   1'b0); // 0 reset reads
    addv(1'b0, 1'b0, 1'b0, 5'd13, 32'h0,        30'h0,   32'h0,        30'h0,   1'b0); // 1
    addv(1'b0, 1'b0, 1'b0, 5'd14, 32'h0,        30'h0,   32'h0,        30'h0,   1'b0); // 2
    addv(1'b0, 1'b1, 1'b0, 5'd12, 32'h8001,     30'h0,   32'h0,        30'h0,   1'b0); // 3 enable
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h100, 32'h8001,     30'h0,   1'b1); // 4 taken
    addv(1'b1, 1'b0, 1'b0, 5'd14, 32'h0,        30'h0,   32'h400,      30'h100, 1'b0); // 5 EXL blocks
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h0,   32'h8003,     30'h100, 1'b0); // 6
    addv(1'b0, 1'b0, 1'b0, 5'd13, 32'h0,        30'h0,   32'h0,        30'h100, 1'b0); // 7 ack
    addv(1'b0, 1'b0, 1'b1, 5'd14, 32'h0,        30'h0,   32'h400,      30'h100, 1'b0); // 8 eret
    addv(1'b0, 1'b0, 1'b0, 5'd12, 32'h0,        30'h0,   32'h8001,     30'h100, 1'b0); // 9
    addv(1'b0, 1'b1, 1'b0, 5'd12, 32'h1,        30'h0,   32'h8001,     30'h100, 1'b0); // 10 IM7=0
    for (int i = 0; i < 5; i++)
      addv(1'b1, 1'b0, 1'b0, 5'd13, 32'h0,      30'h0,   32'h8000,     30'h100, 1'b0); // 11-15 masked
    addv(1'b1, 1'b1, 1'b0, 5'd12, 32'h8001,     30'h0,   32'h1,        30'h100, 1'b0); // 16 enabling write
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h200, 32'h8001,     30'h100, 1'b1); // 17 taken
    addv(1'b1, 1'b0, 1'b1, 5'd12, 32'h0,        30'h0,   32'h8003,     30'h200, 1'b0); // 18 eret, no ack
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h300, 32'h8001,     30'h200, 1'b1); // 19 retaken
    addv(1'b0, 1'b0, 1'b0, 5'd14, 32'h0,        30'h0,   32'hC00,      30'h300, 1'b0); // 20
    addv(1'b0, 1'b0, 1'b1, 5'd12, 32'h0,        30'h0,   32'h8003,     30'h300, 1'b0); // 21 eret
    addv(1'b1, 1'b1, 1'b0, 5'd12, 32'h8001,     30'h40,  32'h8001,     30'h300, 1'b1); // 22 take vs mtc0
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h0,   32'h8003,     30'h40,  1'b0); // 23 EXL won
    addv(1'b0, 1'b1, 1'b0, 5'd14, 32'hFFFFFFFF, 30'h0,   32'h100,      30'h40,  1'b0); // 24 EPC ro
    addv(1'b0, 1'b0, 1'b0, 5'd14, 32'h0,        30'h0,   32'h100,      30'h40,  1'b0); // 25
    addv(1'b0, 1'b1, 1'b0, 5'd5,  32'hFFFFFFFF, 30'h0,   32'h0,        30'h40,  1'b0); // 26 unimpl
    addv(1'b1, 1'b0, 1'b0, 5'd12, 32'h0,        30'h0,   32'h8003,     30'h40,  1'b0); // 27

    next_cycle();
    next_cycle();
    reset = 1'b0;

    @(negedge clock);
    check("handler_pc", handler_pc, 32'h80000180);
    next_cycle();

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].ti, vecs[i].mtc0, vecs[i].eret, vecs[i].rn, vecs[i].wd, vecs[i].npc);
      @(negedge clock);
      check($sformatf("v%0d rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("v%0d EPC", i), {2'b00, EPC}, {2'b00, vecs[i].exp_epc});
      check($sformatf("v%0d TakenInterrupt", i), {31'h0, TakenInterrupt}, {31'h0, vecs[i].exp_taken});
      next_cycle();
    end

    // Reset while EXL=1 and the request is still high
    drive(1'b1, 1'b0, 1'b0, 5'd12, 32'h0, 30'h0);
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clock);
    check("rst_mid status", rd_data, 32'h0);
    check("rst_mid EPC", {2'b00, EPC}, 32'h0);
    check("rst_mid taken", {31'h0, TakenInterrupt}, 32'h0);
    next_cycle();
    drive(1'b1, 1'b0, 1'b0, 5'd13, 32'h0, 30'h0);
    @(negedge clock);
    check("rst_mid cause", rd_data, 32'h8000);
    check("rst_mid taken2", {31'h0, TakenInterrupt}, 32'h0);
    next_cycle();

    // Software interrupt sequence
`ifdef CP0_SOFTWARE_INT_EN
    exp_sw_taken = 1'b1;
    exp_sw_cause = 32'h100;
`else
    exp_sw_taken = 1'b0;
    exp_sw_cause = 32'h0;
`endif
    drive(1'b0, 1'b1, 1'b0, 5'd12, 32'h101, 30'h0);
    next_cycle();
    drive(1'b0, 1'b1, 1'b0, 5'd13, 32'h100, 30'h55);
    @(negedge clock);
    check("sw write-cycle taken", {31'h0, TakenInterrupt}, 32'h0);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 5'd13, 32'h0, 30'h55);
    @(negedge clock);
    check("sw taken", {31'h0, TakenInterrupt}, {31'h0, exp_sw_taken});
    check("sw cause", rd_data, exp_sw_cause);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
